echo_arbiter: RTL
=================

Name: echo_arbiter

Overview:
- Shares one echo datapath (echoReq in, ind_echo out) among NREQ requesters.
- Each requester gets a one-entry holding register. Ready holds are issued round-robin into echoReq, and each issue's source tag is recorded in order.
- Each ind_echo result is routed back to its originating requester through a response queue, so ind_echo is never back-pressured.
- Sits between client logic and the echo block, and owns the outstanding-transaction limit.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, payload width
- DEPTH, 4, max transactions outstanding (issued but not yet delivered); also tag-FIFO and response-FIFO depth; power of 2
- TAGW, clog2(NREQ), tag width (derived)

Ports:
- CLK  input  1  clock
- nRST  input  1  synchronous, active-high reset (1 = reset)
- req__ENA  input  NREQ  per-requester request strobe; asserted only when matching req__RDY=1
- req__RDY  output  NREQ  per-requester holding register empty
- req_v  input  NREQ*WIDTH  payload; slice i belongs to requester i
- echoReq__ENA  output  1  issue to echo datapath
- echoReq__RDY  input  1  echo datapath can accept
- echoReq_v  output  WIDTH  issued payload
- ind_echo__ENA  input  1  result from echo datapath; cannot be stalled
- ind_echo_v  input  WIDTH  result payload
- rsp__ENA  output  NREQ  one-hot delivery strobe
- rsp__RDY  input  NREQ  per-requester sink ready
- rsp_v  output  WIDTH  delivered payload (shared)
- outstanding  output  clog2(DEPTH)+1  current in-flight count
- err  output  1  sticky: ind_echo__ENA seen with tag FIFO empty

Behaviour:
- Reset (nRST=1 at posedge) clears:
  - all hold valids, both FIFOs, outstanding=0, rr pointer=0, err=0.
  - All outputs are 0 except req__RDY = all-ones, and only from the cycle after reset deasserts.
  - During reset, req__RDY=0 and echoReq__ENA=0.
  - Reset mid-operation discards held, queued and in-flight state without delivering any of it.
- Accept: req__RDY[i] = !hold_valid[i], a registered term only. On posedge with req__ENA[i]=1, capture the req_v slice and set hold_valid[i].
- Arbitration:
  - Candidates are the set hold_valid.
  - The winner is the first candidate at or after the rr pointer, searching in increasing index with wrap.
- Issue:
  - echoReq__ENA = any candidate & echoReq__RDY & (outstanding < DEPTH) & !tag_full.
  - echoReq_v = winner's hold data.
  - On issue: clear hold_valid[winner], push winner onto the tag FIFO, rr pointer <= winner+1 mod NREQ.
  - Without an issue, rr is unchanged.
- Same-cycle re-accept: a requester whose hold is issued this cycle cannot be re-accepted in the same cycle, because RDY is registered. Minimum spacing per requester is therefore 2 cycles.
- Min latency is req__ENA to echoReq__ENA = 1 cycle.
- Response capture:
  - On ind_echo__ENA, pop the tag FIFO head and push {tag, ind_echo_v} onto the response FIFO.
  - Results are assumed in issue order; the echo datapath is strictly FIFO.
  - The outstanding limit guarantees the response FIFO never overflows.
- Empty tag FIFO on response: ind_echo__ENA with the tag FIFO empty sets err, and the data is dropped.
- Delivery:
  - Response FIFO head valid with tag t drives rsp__ENA = onehot(t) & rsp__RDY[t], and rsp_v = head data.
  - The FIFO pops when rsp__ENA is nonzero.
  - Head-of-line blocking is intended: a stalled requester blocks the others.
  - Min latency is ind_echo__ENA to rsp__ENA = 1 cycle.
- outstanding counter:
  - +1 on issue, −1 on delivery; both in the same cycle leaves it unchanged.
  - Never exceeds DEPTH and never underflows.
- Full boundary: at outstanding=DEPTH, no issue; holds stay valid and req__RDY stays 0 for the filled slots.
- Simultaneous tag-FIFO push and pop are legal at any occupancy. Full means no push is attempted; empty means the err path applies.

Test Plan:
- Single requester: reset, then req__ENA[2] with v=0x11 → echoReq__ENA next cycle with 0x11. Echo returns 0x11 → rsp__ENA=4'b0100, rsp_v=0x11 one cycle later; outstanding goes 0→1→0.
- Round robin: all 4 requesters send 0xA0..0xA3 in the same cycle with rr=0 and echoReq__RDY=1 → issue order 0,1,2,3 on 4 consecutive cycles. Responses delivered to requesters 0,1,2,3 in order with matching data.
- Pointer wrap: requester 3 issues (rr→0), then requesters 1 and 3 request together → 1 issues first, then 3.
- Outstanding limit: DEPTH=4, echo withholds results, 6 requests → exactly 4 issues, echoReq__ENA stays 0 and outstanding=4. Releasing one result and delivering it → outstanding drops to 3 and the 5th issue follows.
- Backpressure: rsp__RDY[1]=0 while the head is tagged 1 and a tag-0 result sits behind it → no rsp__ENA until rsp__RDY[1]=1. Then tag 1 is delivered, then tag 0. ind_echo continues to be absorbed without loss.
- Reset/error: reset with 2 transactions in flight, then ind_echo__ENA pulses → err=1, no rsp__ENA, outstanding=0. Next reset clears err.

Source files
------------

// File: rtl/echo_arbiter.sv
// echo_arbiter: shares one strictly in-order echo datapath among NREQ requesters.
// Latency: req__ENA -> echoReq__ENA 1 cycle minimum; ind_echo__ENA -> rsp__ENA 1 cycle minimum.
// Backpressure: echoReq__RDY and the outstanding limit stall issue; rsp__RDY stalls delivery (head-of-line); ind_echo is never stalled.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-high reset
//   req__ENA/req__RDY/req_v   per-requester one-entry holding registers (payload slice i = requester i)
//   echoReq__ENA/RDY/v        round-robin issue into the echo datapath
//   ind_echo__ENA/v           echo results, returned in issue order
//   rsp__ENA/RDY/rsp_v        one-hot delivery of each result to its originating requester
//   outstanding               issued-but-not-delivered count
//   err                       sticky: a result arrived with no transaction in flight

// Generic synchronous FIFO, DEPTH a power of two (>= 2).
// Latency: pushed data is visible at the head the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module echo_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

module echo_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req__ENA,
  output logic [NREQ-1:0]         req__RDY,
  input  logic [NREQ*WIDTH-1:0]   req_v,
  output logic                    echoReq__ENA,
  input  logic                    echoReq__RDY,
  output logic [WIDTH-1:0]        echoReq_v,
  input  logic                    ind_echo__ENA,
  input  logic [WIDTH-1:0]        ind_echo_v,
  output logic [NREQ-1:0]         rsp__ENA,
  input  logic [NREQ-1:0]         rsp__RDY,
  output logic [WIDTH-1:0]        rsp_v,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err
);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int RW = TAGW + WIDTH;

  // r_live is low during reset and rises the cycle after reset is released,
  // keeping req__RDY a purely registered term.
  logic             r_live;
  logic [NREQ-1:0]  r_hold_vld;
  logic [WIDTH-1:0] r_hold_dat [NREQ];
  logic [TAGW-1:0]  r_rr;
  logic [OW-1:0]    r_outstanding;
  logic             r_err;

  logic             w_any;
  logic [TAGW-1:0]  w_win;
  logic [TAGW-1:0]  w_rr_next;
  int               w_idx;
  logic             w_issue;
  logic             w_deliver;

  logic [TAGW-1:0]  w_tag_head;
  logic             w_tag_empty;
  logic             w_tag_full;
  logic             w_rsp_push;
  logic [RW-1:0]    w_rsp_head;
  logic             w_rsp_empty;
  logic             w_rsp_full;
  logic [TAGW-1:0]  w_rsp_tag;

  assign req__RDY = ~r_hold_vld & {NREQ{r_live}};

  // First valid hold at or after the rr pointer, wrapping at NREQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_any && r_hold_vld[w_idx]) begin
        w_any = 1'b1;
        w_win = TAGW'(w_idx);
      end
    end
  end

  assign w_rr_next = (w_win == TAGW'(NREQ - 1)) ? '0 : w_win + TAGW'(1);

  assign w_issue = w_any && echoReq__RDY && (r_outstanding < OW'(DEPTH)) &&
                   !w_tag_full && r_live && !nRST;
  assign echoReq__ENA = w_issue;
  assign echoReq_v    = w_any ? r_hold_dat[w_win] : '0;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_live     <= 1'b0;
      r_hold_vld <= '0;
      r_rr       <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_issue) r_rr <= w_rr_next;
      for (int i = 0; i < NREQ; i++) begin
        if (w_issue && (w_win == TAGW'(i))) r_hold_vld[i] <= 1'b0;
        // Gate with RDY so a stray strobe cannot overwrite a held payload.
        if (req__ENA[i] && req__RDY[i])     r_hold_vld[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req__ENA[i] && req__RDY[i]) r_hold_dat[i] <= req_v[i*WIDTH +: WIDTH];
    end
  end

  // Source tag of every issue, in issue order; results return in the same order.
  echo_fifo #(.W(TAGW), .DEPTH(DEPTH)) u_tag_fifo (
    .i_clk      (CLK),
    .i_rst      (nRST),
    .i_push     (w_issue),
    .i_push_dat (w_win),
    .i_pop      (ind_echo__ENA),
    .o_head_dat (w_tag_head),
    .o_empty    (w_tag_empty),
    .o_full     (w_tag_full)
  );

  // Cannot overflow: its occupancy never exceeds outstanding, which is capped at DEPTH.
  assign w_rsp_push = ind_echo__ENA && !w_tag_empty && !nRST;

  echo_fifo #(.W(RW), .DEPTH(DEPTH)) u_rsp_fifo (
    .i_clk      (CLK),
    .i_rst      (nRST),
    .i_push     (w_rsp_push),
    .i_push_dat ({w_tag_head, ind_echo_v}),
    .i_pop      (w_deliver),
    .o_head_dat (w_rsp_head),
    .o_empty    (w_rsp_empty),
    .o_full     (w_rsp_full)
  );

  assign w_rsp_tag = w_rsp_head[RW-1 -: TAGW];

  // Only the head's owner is considered, so a stalled requester blocks the rest.
  always_comb begin
    rsp__ENA = '0;
    if (!w_rsp_empty && r_live && !nRST) rsp__ENA = (NREQ'(1) << w_rsp_tag) & rsp__RDY;
  end

  assign w_deliver = |rsp__ENA;
  assign rsp_v     = w_rsp_empty ? '0 : w_rsp_head[WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_issue, w_deliver})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      // A result with nothing in flight has no owner: drop it and flag.
      if (ind_echo__ENA && w_tag_empty) r_err <= 1'b1;
    end
  end

  assign outstanding = r_outstanding;
  assign err         = r_err;

  // Structurally unreachable given the outstanding cap; kept observable for debug.
  logic w_unused;
  assign w_unused = w_rsp_full;
endmodule
